// File: rtl/velocity_pkg.sv
// Shared encodings and constants for the encoder-velocity sequencer.
package velocity_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DIFF,
    S_SCALE,
    S_PRESENT
  } state_e;

  localparam int DEFAULT_COUNTS_PER_REV = 1496;

  // 3.625 * d  ==  (d << 1) + d + (d >> 1) + (d >> 3)
  localparam int SCALE_SH_X2     = 1;
  localparam int SCALE_SH_HALF   = 1;
  localparam int SCALE_SH_EIGHTH = 3;

endpackage

// File: rtl/vel_tick_gen.sv
// Sample-period prescaler: counts 0..SAMPLE_DIV-1 while enabled and emits a
// one-cycle tick on the last count; held at zero while disabled.
module vel_tick_gen #(
  parameter int SAMPLE_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int                CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_tick = i_enable && (count_q == CNT_LAST);

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = '0;
    if (i_enable && !o_tick) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/velocity_sample_sequencer.sv
// Periodic encoder sampler: capture, wrap-corrected difference, x3.625 scale,
// valid/ready presentation. Define VELOCITY_AVG_EN for a 2-tap output average.
module velocity_sample_sequencer
  import velocity_pkg::*;
#(
  parameter int SAMPLE_DIV     = 50000,
  parameter int POS_W          = 16,
  parameter int COUNTS_PER_REV = DEFAULT_COUNTS_PER_REV
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [POS_W-1:0] i_position,
  output logic [POS_W-1:0] o_velocity,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun
);

  localparam int               EXT_W   = POS_W + 2;
  localparam logic [POS_W-1:0] CPR     = POS_W'(COUNTS_PER_REV);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(COUNTS_PER_REV - 1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] curr_q, curr_d;
  logic [POS_W-1:0] prev_q, prev_d;
  logic [POS_W-1:0] d_q, d_d;
  logic [POS_W-1:0] vel_q, vel_d;
  logic             primed_q, primed_d;
  logic             overrun_q, overrun_d;
  logic             tick;

  logic [POS_W-1:0] pos_clamped;
  logic [POS_W-1:0] diff;
  logic [EXT_W-1:0] d_ext;
  logic [EXT_W-1:0] scaled;
  logic [POS_W-1:0] v_sat;
  logic [POS_W-1:0] v_out;

  vel_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_enable (i_enable),
    .o_tick   (tick)
  );

  assign pos_clamped = (i_position >= CPR) ? POS_MAX : i_position;

  // prev <= COUNTS_PER_REV-1, so (CPR - prev) never underflows and the sum stays below CPR.
  assign diff = (curr_q >= prev_q) ? (curr_q - prev_q) : (curr_q + (CPR - prev_q));

  assign d_ext  = {2'b00, d_q};
  assign scaled = (d_ext << SCALE_SH_X2) + d_ext + (d_ext >> SCALE_SH_HALF)
                + (d_ext >> SCALE_SH_EIGHTH);
  assign v_sat  = (|scaled[EXT_W-1:POS_W]) ? {POS_W{1'b1}} : scaled[POS_W-1:0];

`ifdef VELOCITY_AVG_EN
  logic [POS_W-1:0] vlast_q, vlast_d;
  logic [POS_W:0]   avg_sum;

  assign avg_sum = {1'b0, v_sat} + {1'b0, vlast_q};
  assign v_out   = POS_W'(avg_sum >> 1);
`else
  assign v_out = v_sat;
`endif

  always_comb begin
    state_d   = state_q;
    curr_d    = curr_q;
    prev_d    = prev_q;
    d_d       = d_q;
    vel_d     = vel_q;
    primed_d  = primed_q;
    overrun_d = overrun_q;
`ifdef VELOCITY_AVG_EN
    vlast_d   = vlast_q;
`endif

    case (state_q)
      S_IDLE:    if (i_enable) state_d = S_WAIT;
      S_WAIT:    if (tick) state_d = S_CAPTURE;
      S_CAPTURE: begin
        prev_d = curr_q;
        curr_d = pos_clamped;
        if (!primed_q) begin
          primed_d = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_DIFF;
        end
      end
      S_DIFF: begin
        d_d     = diff;
        state_d = S_SCALE;
      end
      S_SCALE: begin
        vel_d   = v_out;
`ifdef VELOCITY_AVG_EN
        vlast_d = v_sat;
`endif
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        // A tick here cannot be serviced; the held sample is kept and the period is lost.
        if (tick)    overrun_d = 1'b1;
        if (i_ready) state_d   = S_WAIT;
      end
      default:   state_d = S_IDLE;
    endcase

    if (!i_enable) begin
      state_d   = S_IDLE;
      primed_d  = 1'b0;
      overrun_d = 1'b0;
`ifdef VELOCITY_AVG_EN
      vlast_d   = '0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      curr_q    <= '0;
      prev_q    <= '0;
      d_q       <= '0;
      vel_q     <= '0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef VELOCITY_AVG_EN
      vlast_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      curr_q    <= curr_d;
      prev_q    <= prev_d;
      d_q       <= d_d;
      vel_q     <= vel_d;
      primed_q  <= primed_d;
      overrun_q <= overrun_d;
`ifdef VELOCITY_AVG_EN
      vlast_q   <= vlast_d;
`endif
    end
  end

  assign o_valid    = (state_q == S_PRESENT);
  assign o_velocity = vel_q;
  assign o_overrun  = overrun_q;

endmodule
